// File: rtl/enc_pkg.sv
// Shared types and constants for the quadrature decoder.
//   quad_state_t : quadrature state, encoded so the value equals {A,B}
//   dec_fsm_t    : control FSM states (INIT loads levels, RUN decodes steps)
//   SYNC_DEPTH   : number of synchronizer flops per encoder channel
//   cw_next()    : the state one clockwise step after a given state
package enc_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q10 = 2'b10,
        Q11 = 2'b11
    } quad_state_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dec_fsm_t;

    // Clockwise order is Q00 -> Q10 -> Q11 -> Q01 -> Q00.
    function automatic quad_state_t cw_next(input quad_state_t s);
        quad_state_t n;
        case (s)
            Q00:     n = Q10;
            Q10:     n = Q11;
            Q11:     n = Q01;
            default: n = Q00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/enc_debounce.sv
// One encoder channel: SYNC_DEPTH-flop synchronizer followed by a
// debounce filter.
//   clk, reset : clock and synchronous active-high reset
//   din        : raw asynchronous channel input
//   load       : when high, the filtered bit is copied from the
//                synchronized bit and the debounce counter is cleared
//   sync_out   : synchronized bit
//   filt_out   : debounced bit
// The counter counts cycles in which the synchronized bit differs from the
// filtered bit and clears whenever they agree. Once it has reached
// DEBOUNCE_CYCLES, the next cycle that still sees the difference moves the
// filtered bit to the new level.
module enc_debounce
    import enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic load,
    output logic sync_out,
    output logic filt_out
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_CYCLES);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic [DB_W-1:0]       cnt_q, cnt_d;
    logic                  filt_q, filt_d;
    logic                  sync_bit;

    assign sync_bit = sync_q[SYNC_DEPTH-1];

    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], din};
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (load) begin
            filt_d = sync_bit;
            cnt_d  = '0;
        end else if (sync_bit == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            filt_d = sync_bit;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign sync_out = sync_bit;
    assign filt_out = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder.
//   clk, reset   : clock and synchronous active-high reset
//   enc_a, enc_b : asynchronous encoder channels
//   err_clr      : clears the sticky error flag
//   cw, ccw      : one-cycle pulse per accepted clockwise / counterclockwise step
//   err          : sticky flag, set by a transition that changes both bits
//   pos          : signed, wrapping net step count
// Each channel is synchronized and debounced in enc_debounce. After reset the
// FSM stays in INIT for DEBOUNCE_CYCLES+2 cycles, copying the synchronized
// levels into the filters and the quadrature state so that the first RUN
// cycle starts from the current encoder position without a spurious pulse.
// All outputs come straight from flops.
module quad_decoder
    import enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    err_clr,
    output logic                    cw,
    output logic                    ccw,
    output logic                    err,
    output logic signed [CNT_W-1:0] pos
);

    localparam int INIT_W = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 1);
    localparam logic signed [CNT_W-1:0] POS_ONE = CNT_W'(1);

    // Index 1 carries channel A, index 0 carries channel B, so that the
    // two-bit vectors read directly as {A,B}.
    logic [1:0] enc_in;
    logic [1:0] sync_bits;
    logic [1:0] filt_bits;
    logic       init_load;

    dec_fsm_t              state_q, state_d;
    logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;
    quad_state_t           quad_q, quad_d;
    logic                  cw_q, cw_d;
    logic                  ccw_q, ccw_d;
    logic                  err_q, err_d;
    logic signed [CNT_W-1:0] pos_q, pos_d;
    logic                  illegal;

    assign enc_in    = {enc_a, enc_b};
    assign init_load = (state_q == INIT);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            enc_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset   (reset),
                .din     (enc_in[gi]),
                .load    (init_load),
                .sync_out(sync_bits[gi]),
                .filt_out(filt_bits[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        quad_d     = quad_q;
        cw_d       = 1'b0;
        ccw_d      = 1'b0;
        err_d      = err_q;
        pos_d      = pos_q;
        illegal    = 1'b0;

        case (state_q)
            INIT: begin
                quad_d = quad_state_t'(sync_bits);
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            RUN: begin
                // quad_q always holds last cycle's filtered level, so any
                // difference is a single step either way or a double change.
                quad_d = quad_state_t'(filt_bits);
                if (filt_bits != quad_q) begin
                    if (filt_bits == cw_next(quad_q)) begin
                        cw_d  = 1'b1;
                        pos_d = pos_q + POS_ONE;
                    end else if (cw_next(quad_state_t'(filt_bits)) == quad_q) begin
                        ccw_d = 1'b1;
                        pos_d = pos_q - POS_ONE;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        // A new illegal transition outranks a simultaneous clear.
        if (illegal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            quad_q     <= Q00;
            cw_q       <= 1'b0;
            ccw_q      <= 1'b0;
            err_q      <= 1'b0;
            pos_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            quad_q     <= quad_d;
            cw_q       <= cw_d;
            ccw_q      <= ccw_d;
            err_q      <= err_d;
            pos_q      <= pos_d;
        end
    end

    assign cw  = cw_q;
    assign ccw = ccw_q;
    assign err = err_q;
    assign pos = pos_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder with DEBOUNCE_CYCLES=4 and CNT_W=4.
// Expected pulses are queued when a level is driven and checked by the
// monitor when cw/ccw appears (direction, cycle and pos).
module tb_quad_decoder;
    import enc_pkg::*;

    localparam int DB  = 4;
    localparam int CW  = 4;
    // From the negedge that drives a new level to the negedge at which the
    // resulting pulse is visible: one cycle to the sampling edge, then DB+3.
    localparam int LAT = DB + 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic err_clr = 1'b0;
    logic cw, ccw, err;
    logic signed [CW-1:0] pos;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int cw_seen = 0;
    int ccw_seen = 0;

    typedef struct {
        logic                 is_cw;
        int                   exp_cyc;
        logic signed [CW-1:0] exp_pos;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [1:0] cur_ab = 2'b00;
    logic signed [CW-1:0] exp_pos = '0;

    quad_decoder #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enc_a  (enc_a),
        .enc_b  (enc_b),
        .err_clr(err_clr),
        .cw     (cw),
        .ccw    (ccw),
        .err    (err),
        .pos    (pos)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Clockwise order 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] tb_cw(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Pulse monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (cw || ccw) begin
            if (cw) cw_seen++;
            if (ccw) ccw_seen++;
            tests++;
            if (cw && ccw) begin
                fails++;
                $display("FAIL both_pulses: cw=%0b ccw=%0b at cycle %0d, required never both", cw, ccw, cyc);
            end else if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: cw=%0b ccw=%0b at cycle %0d, required no pulse", cw, ccw, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (cw !== mon_e.is_cw) begin
                    fails++;
                    $display("FAIL pulse_dir: cw=%0b, required cw=%0b at cycle %0d", cw, mon_e.is_cw, cyc);
                end
                tests++;
                if (cyc !== mon_e.exp_cyc) begin
                    fails++;
                    $display("FAIL pulse_latency: pulse at cycle %0d, required %0d", cyc, mon_e.exp_cyc);
                end
                tests++;
                if (pos !== mon_e.exp_pos) begin
                    fails++;
                    $display("FAIL pulse_pos: pos=%0d, required %0d", pos, mon_e.exp_pos);
                end
            end
        end
    end

    // Drive a new {A,B} level on a negedge, queue the expected pulse, hold it.
    task automatic drive_step(input logic [1:0] ab, input int hold);
        @(negedge clk);
        enc_a = ab[1];
        enc_b = ab[0];
        if (ab == tb_cw(cur_ab)) begin
            exp_pos = exp_pos + 4'sd1;
            sb.push_back('{is_cw: 1'b1, exp_cyc: cyc + LAT, exp_pos: exp_pos});
        end else if (tb_cw(ab) == cur_ab) begin
            exp_pos = exp_pos - 4'sd1;
            sb.push_back('{is_cw: 1'b0, exp_cyc: cyc + LAT, exp_pos: exp_pos});
        end
        cur_ab = ab;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] ab, input int cycles);
        @(negedge clk);
        reset = 1'b1;
        err_clr = 1'b0;
        enc_a = ab[1];
        enc_b = ab[0];
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        cur_ab = ab;
        exp_pos = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({cw, ccw, err, pos} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: cw=%0b ccw=%0b err=%0b pos=%0d, required all 0", cw, ccw, err, pos);
        end
        tests++;
        if (dut.state_q !== INIT) begin
            fails++;
            $display("FAIL reset_state: state=%0d, required INIT", dut.state_q);
        end
        reset = 1'b0;
        sb.delete();
        cur_ab = 2'b11;
        exp_pos = '0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            tests++;
            if (dut.state_q !== ((j >= DB + 2) ? RUN : INIT)) begin
                fails++;
                $display("FAIL init_timing: state=%0d at cycle %0d after reset, required %0d",
                         dut.state_q, j, (j >= DB + 2) ? RUN : INIT);
            end
            tests++;
            if ({cw, ccw, err, pos} !== '0) begin
                fails++;
                $display("FAIL init_quiet: cw=%0b ccw=%0b err=%0b pos=%0d at cycle %0d, required all 0",
                         cw, ccw, err, pos, j);
            end
        end
    endtask

    task automatic test_cw_sequence();
        int c0, k0;
        do_reset(2'b00, 2);
        repeat (10) @(negedge clk);
        c0 = cw_seen;
        k0 = ccw_seen;
        drive_step(2'b10, 10);
        drive_step(2'b11, 10);
        drive_step(2'b01, 10);
        drive_step(2'b00, 10);
        repeat (3) @(negedge clk);
        tests++;
        if (cw_seen - c0 !== 4) begin
            fails++;
            $display("FAIL cw_count: %0d cw pulses, required 4", cw_seen - c0);
        end
        tests++;
        if (ccw_seen - k0 !== 0) begin
            fails++;
            $display("FAIL cw_seq_ccw: %0d ccw pulses, required 0", ccw_seen - k0);
        end
        tests++;
        if (pos !== 4'sd4) begin
            fails++;
            $display("FAIL cw_seq_pos: pos=%0d, required 4", pos);
        end
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL cw_seq_pending: %0d expected pulses missing, required 0", sb.size());
        end
    endtask

    task automatic test_glitch();
        int c0, k0;
        c0 = cw_seen;
        k0 = ccw_seen;
        @(negedge clk);
        enc_a = 1'b1;
        repeat (3) @(negedge clk);
        enc_a = 1'b0;
        repeat (15) @(negedge clk);
        tests++;
        if ((cw_seen - c0) + (ccw_seen - k0) !== 0) begin
            fails++;
            $display("FAIL glitch_pulse: %0d pulses, required 0", (cw_seen - c0) + (ccw_seen - k0));
        end
        tests++;
        if (pos !== exp_pos) begin
            fails++;
            $display("FAIL glitch_pos: pos=%0d, required %0d", pos, exp_pos);
        end
    endtask

    task automatic test_illegal();
        int c0, k0;
        c0 = cw_seen;
        k0 = ccw_seen;
        // 00 -> 11 in one cycle
        @(negedge clk);
        enc_a = 1'b1;
        enc_b = 1'b1;
        cur_ab = 2'b11;
        repeat (LAT - 1) @(negedge clk);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL illegal_early: err=%0b one cycle before set, required 0", err);
        end
        @(negedge clk);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL illegal_set: err=%0b, required 1", err);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (pos !== exp_pos || (cw_seen - c0) + (ccw_seen - k0) !== 0) begin
            fails++;
            $display("FAIL illegal_nopulse: pos=%0d pulses=%0d, required pos=%0d pulses=0",
                     pos, (cw_seen - c0) + (ccw_seen - k0), exp_pos);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: err=%0b, required 0", err);
        end
        // 11 -> 00 landing on the same edge as err_clr
        @(negedge clk);
        enc_a = 1'b0;
        enc_b = 1'b0;
        cur_ab = 2'b00;
        repeat (LAT - 1) @(negedge clk);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL coincide_pre: err=%0b, required 0", err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL coincide_set_wins: err=%0b, required 1", err);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: err=%0b, required 1", err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear2: err=%0b, required 0", err);
        end
    endtask

    task automatic test_wrap();
        int k0;
        do_reset(2'b00, 2);
        repeat (10) @(negedge clk);
        drive_step(2'b10, 10);
        drive_step(2'b11, 10);
        drive_step(2'b01, 10);
        drive_step(2'b00, 10);
        drive_step(2'b10, 10);
        drive_step(2'b11, 10);
        drive_step(2'b01, 10);
        tests++;
        if (pos !== 4'sd7) begin
            fails++;
            $display("FAIL wrap_max: pos=%0d, required 7", pos);
        end
        drive_step(2'b00, 10);
        tests++;
        if (pos !== -4'sd8) begin
            fails++;
            $display("FAIL wrap_up: pos=%0d, required -8", pos);
        end
        k0 = ccw_seen;
        drive_step(2'b01, 10);
        tests++;
        if (pos !== 4'sd7) begin
            fails++;
            $display("FAIL wrap_down: pos=%0d, required 7", pos);
        end
        tests++;
        if (ccw_seen - k0 !== 1) begin
            fails++;
            $display("FAIL wrap_ccw_count: %0d ccw pulses, required 1", ccw_seen - k0);
        end
    endtask

    task automatic test_reset_mid();
        int c0, k0;
        // Reset while the 01 -> 00 edge is still being debounced.
        @(negedge clk);
        enc_a = 1'b0;
        enc_b = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        cur_ab = 2'b00;
        exp_pos = '0;
        tests++;
        if ({cw, ccw, err, pos} !== '0 || dut.state_q !== INIT) begin
            fails++;
            $display("FAIL mid_debounce_reset: cw=%0b ccw=%0b err=%0b pos=%0d state=%0d, required zeros and INIT",
                     cw, ccw, err, pos, dut.state_q);
        end
        c0 = cw_seen;
        k0 = ccw_seen;
        repeat (20) @(negedge clk);
        tests++;
        if ((cw_seen - c0) + (ccw_seen - k0) !== 0 || pos !== 4'sd0 || dut.state_q !== RUN) begin
            fails++;
            $display("FAIL mid_debounce_after: pulses=%0d pos=%0d state=%0d, required 0, 0, RUN",
                     (cw_seen - c0) + (ccw_seen - k0), pos, dut.state_q);
        end
        // Reset during the cw pulse of 00 -> 10.
        drive_step(2'b10, 1);
        repeat (LAT) @(negedge clk);
        tests++;
        if (cw !== 1'b1) begin
            fails++;
            $display("FAIL pulse_before_reset: cw=%0b, required 1", cw);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({cw, ccw, err, pos} !== '0 || dut.state_q !== INIT) begin
            fails++;
            $display("FAIL pulse_reset: cw=%0b ccw=%0b err=%0b pos=%0d state=%0d, required zeros and INIT",
                     cw, ccw, err, pos, dut.state_q);
        end
        sb.delete();
        cur_ab = 2'b10;
        exp_pos = '0;
        c0 = cw_seen;
        k0 = ccw_seen;
        repeat (20) @(negedge clk);
        tests++;
        if ((cw_seen - c0) + (ccw_seen - k0) !== 0 || pos !== 4'sd0) begin
            fails++;
            $display("FAIL pulse_reset_after: pulses=%0d pos=%0d, required 0 and 0",
                     (cw_seen - c0) + (ccw_seen - k0), pos);
        end
    endtask

    initial begin
        test_reset();
        test_cw_sequence();
        test_glitch();
        test_illegal();
        test_wrap();
        test_reset_mid();
        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL pending_pulses: %0d expected pulses never seen, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive clk cycles a synchronized input must hold a new level before it is accepted (range 1..65535).
REQ-002 SHALL have parameter CNT_W, default 16: width of the signed position counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enc_a, input, 1 bit: encoder channel A, asynchronous to clk.
REQ-006 SHALL have port enc_b, input, 1 bit: encoder channel B, asynchronous to clk.
REQ-007 SHALL have port err_clr, input, 1 bit: clears the sticky error flag.
REQ-008 SHALL have port cw, output, 1 bit: one-cycle pulse per accepted clockwise quadrature step.
REQ-009 SHALL have port ccw, output, 1 bit: one-cycle pulse per accepted counterclockwise quadrature step.
REQ-010 SHALL have port err, output, 1 bit: sticky flag for an illegal two-bit transition.
REQ-011 SHALL have port pos, output, CNT_W bits, signed: net step count.

Function
REQ-012 SHALL pass enc_a and enc_b each through a 2-flop synchronizer.
REQ-013 SHALL debounce each synchronized bit: a per-bit counter increments while the synchronized bit differs from the filtered bit and clears when they match; the filtered bit takes the new level when the counter reaches DEBOUNCE_CYCLES.
REQ-014 SHALL implement a control FSM with states INIT and RUN.
REQ-015 In INIT, SHALL copy the synchronized bits straight into the filtered bits and the quadrature state, with cw=ccw=0.
REQ-016 SHALL move from INIT to RUN after exactly DEBOUNCE_CYCLES+2 cycles in INIT.
REQ-017 In RUN, SHALL track quadrature state {A,B} in the order Q00->Q10->Q11->Q01->Q00, which is the clockwise direction.
REQ-018 On a filtered change to the next clockwise state, SHALL assert cw for exactly one cycle and increment pos by 1.
REQ-019 On a filtered change to the previous state, SHALL assert ccw for exactly one cycle and decrement pos by 1.
REQ-020 On a cycle where both filtered bits change, SHALL set err, assert neither cw nor ccw, leave pos unchanged, and load the new state.
REQ-021 SHALL never assert cw and ccw in the same cycle.
REQ-022 pos SHALL wrap in two's complement (max+1 -> min, min-1 -> max) with no saturation.
REQ-023 Latency: if a new input level is first sampled at clk edge k and then held, the corresponding cw/ccw pulse SHALL be asserted in cycle k+DEBOUNCE_CYCLES+3; pos SHALL update in that same cycle.
REQ-024 cw, ccw, err and pos SHALL be driven directly from registers.
REQ-025 err_clr SHALL clear err on the next cycle; if an illegal transition occurs in the same cycle as err_clr, set SHALL win and err SHALL stay 1.
REQ-026 A pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change.

Reset
REQ-027 When reset=1 at a clk edge, SHALL clear synchronizers, debounce counters, filtered bits, cw, ccw, err and pos to 0 and set the FSM to INIT.
REQ-028 Reset SHALL take priority over all other inputs, including mid-debounce and during an output pulse.
REQ-029 The first RUN state after reset SHALL be the INIT-loaded level and SHALL NOT generate a pulse or error.

Structure
REQ-030 Shared package enc_pkg SHALL hold typedef quad_state_t {Q00,Q10,Q11,Q01}, typedef dec_fsm_t {INIT,RUN}, and the localparam for the synchronizer depth (2).
REQ-031 SHALL instantiate one sub-module enc_debounce (2-flop synchronizer plus debounce counter for one bit) twice, once for A and once for B.
REQ-032 cw/ccw SHALL directly feed the existing channel-select block's cw/ccw inputs without further conditioning.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-033 Hold enc_a=1, enc_b=1 through reset release, then for 20 cycles -> FSM reaches RUN after 6 cycles; cw=ccw=0, pos=0, err=0 throughout.
REQ-034 Drive 00->10->11->01->00, each level held 10 cycles -> exactly four cw pulses, each 7 cycles after its edge; pos=4; ccw never asserted.
REQ-035 Drive enc_a high for 3 cycles and then low -> no cw/ccw; pos unchanged.
REQ-036 Drive 00->11 in one cycle, held -> err=1, no pulse, pos unchanged; then err_clr=1 for 1 cycle -> err=0 on the next cycle; illegal edge coincident with err_clr -> err stays 1.
REQ-037 With CNT_W=4, drive 7 cw steps then 1 more -> pos=7 then -8; then 1 ccw step -> pos=7.
REQ-038 Assert reset for 1 cycle mid-debounce and once during a cw pulse -> all outputs 0 on the next cycle, INIT re-entered, no pulse for the interrupted edge.
